// File: rtl/wb_cache_memory.sv
// Write-back, direct-mapped cache with multi-word blocks in front of a
// fixed-latency backing RAM, sequenced by a single controller FSM.
module wb_cache_memory #(
  parameter int ramWidth   = 8,
  parameter int addrSize   = 8,
  parameter int indexBits  = 2,
  parameter int offsetBits = 1,
  parameter int ramLatency = 2
) (
  input  logic                clk,
  input  logic                clrN,
  input  logic                req,
  input  logic [1:0]          cntrl,
  input  logic                isIndirect,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] dataIn,
  output logic [ramWidth-1:0] dataOut,
  output logic                dataReady,
  output logic                busy,
  output logic [15:0]         hitCount,
  output logic [15:0]         missCount
);

  localparam int W     = 1 << offsetBits;
  localparam int LINES = 1 << indexBits;
  localparam int TAGW  = addrSize - indexBits - offsetBits;
  localparam int DEPTH = 1 << addrSize;
  localparam int LATW  = (ramLatency > 1) ? $clog2(ramLatency) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RELOOK, FLUSH, DONE} state_t;

  state_t                 state_q;
  logic [addrSize-1:0]    addr_q;
  logic [ramWidth-1:0]    wdata_q;
  logic                   is_write_q;
  logic                   indirect_q;
  logic                   flushing_q;
  logic [indexBits-1:0]   flush_idx_q;
  logic [offsetBits-1:0]  word_q;
  logic [LATW-1:0]        lat_q;
  logic [ramWidth-1:0]    dout_q;
  logic                   ready_q;
  logic                   busy_q;
  logic [15:0]            hit_q;
  logic [15:0]            miss_q;
  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAGW-1:0]        tag_q  [LINES];
  logic [ramWidth-1:0]    line_q [LINES*W];
  logic [ramWidth-1:0]    ram_q  [DEPTH];

  logic [TAGW-1:0]        req_tag;
  logic [indexBits-1:0]   req_idx;
  logic [offsetBits-1:0]  req_off;
  logic                   hit;
  logic [ramWidth-1:0]    hit_word;
  logic [addrSize-1:0]    ptr_addr;
  logic [indexBits-1:0]   vic_idx;
  logic [addrSize-1:0]    evict_addr;
  logic [addrSize-1:0]    fill_addr;
  logic                   xfer_last;

  assign req_tag    = addr_q[addrSize-1 -: TAGW];
  assign req_idx    = addr_q[offsetBits +: indexBits];
  assign req_off    = addr_q[offsetBits-1:0];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word   = line_q[{req_idx, req_off}];
  // During a flush the victim is the scanned line rather than the request's line.
  assign vic_idx    = flushing_q ? flush_idx_q : req_idx;
  assign evict_addr = {tag_q[vic_idx], vic_idx, word_q};
  assign fill_addr  = {req_tag, req_idx, word_q};
  assign xfer_last  = (lat_q == LATW'(ramLatency - 1));

  generate
    if (ramWidth >= addrSize) begin : g_ptr_trunc
      assign ptr_addr = hit_word[addrSize-1:0];
    end else begin : g_ptr_ext
      assign ptr_addr = {{(addrSize-ramWidth){1'b0}}, hit_word};
    end
  endgenerate

  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      indirect_q  <= 1'b0;
      flushing_q  <= 1'b0;
      flush_idx_q <= '0;
      word_q      <= '0;
      lat_q       <= '0;
      dout_q      <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      for (int i = 0; i < LINES*W; i++) line_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && cntrl != 2'b00) begin
            addr_q      <= addr;
            wdata_q     <= dataIn;
            is_write_q  <= (cntrl == 2'b10);
            indirect_q  <= isIndirect && (cntrl == 2'b01);
            flushing_q  <= (cntrl == 2'b11);
            flush_idx_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= (cntrl == 2'b11) ? FLUSH : LOOKUP;
          end
        end
        LOOKUP, RELOOK: begin
          if (state_q == LOOKUP) begin
            if (hit) begin
              if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else begin
              if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end
          end
          if (hit) begin
            if (is_write_q) begin
              line_q[{req_idx, req_off}] <= wdata_q;
              dirty_q[req_idx]           <= 1'b1;
              ready_q                    <= 1'b1;
              state_q                    <= DONE;
            end else if (indirect_q) begin
              // Second stage reuses the LOOKUP path with the fetched pointer.
              addr_q     <= ptr_addr;
              indirect_q <= 1'b0;
              state_q    <= LOOKUP;
            end else begin
              dout_q  <= hit_word;
              ready_q <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (xfer_last) begin
            ram_q[evict_addr] <= line_q[{vic_idx, word_q}];
            lat_q             <= '0;
            if (&word_q) begin
              word_q           <= '0;
              dirty_q[vic_idx] <= 1'b0;
              if (!flushing_q) begin
                state_q <= FILL;
              end else if (&flush_idx_q) begin
                ready_q <= 1'b1;
                state_q <= DONE;
              end else begin
                flush_idx_q <= flush_idx_q + 1'b1;
                state_q     <= FLUSH;
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        FILL: begin
          if (xfer_last) begin
            line_q[{req_idx, word_q}] <= ram_q[fill_addr];
            lat_q                     <= '0;
            if (&word_q) begin
              word_q           <= '0;
              valid_q[req_idx] <= 1'b1;
              dirty_q[req_idx] <= 1'b0;
              tag_q[req_idx]   <= req_tag;
              state_q          <= RELOOK;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        FLUSH: begin
          if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
            state_q <= EVICT;
          end else if (&flush_idx_q) begin
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            flush_idx_q <= flush_idx_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut   = dout_q;
  assign dataReady = ready_q;
  assign busy      = busy_q;
  assign hitCount  = hit_q;
  assign missCount = miss_q;

endmodule

// File: tb/tb_wb_cache_memory.sv
// Self-checking bench: a transaction-level memory/tag model predicts latency,
// read data and counters; directed test-plan cases followed by random traffic.
module tb_wb_cache_memory;

  localparam int W     = 2;
  localparam int LINES = 4;
  localparam int WL    = 4;   // words per block * cycles per word

  logic        clk = 1'b0;
  logic        clrN = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  cntrl = 2'b00;
  logic        isIndirect = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  dataIn = 8'h00;
  logic [7:0]  dataOut;
  logic        dataReady;
  logic        busy;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  int checks = 0;
  int errors = 0;

  // Architectural memory view plus tag state, used only to derive latencies.
  logic [7:0] mem [256];
  bit         cvalid [LINES];
  bit         cdirty [LINES];
  int         ctag   [LINES];
  int         m_hits;
  int         m_misses;
  logic [7:0] m_dout;

  wb_cache_memory #(
    .ramWidth(8), .addrSize(8), .indexBits(2), .offsetBits(1), .ramLatency(2)
  ) dut (
    .clk(clk), .clrN(clrN), .req(req), .cntrl(cntrl), .isIndirect(isIndirect),
    .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .dataReady(dataReady),
    .busy(busy), .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < LINES; i++) begin
      cvalid[i] = 1'b0;
      cdirty[i] = 1'b0;
      ctag[i]   = 0;
    end
    m_hits = 0;
    m_misses = 0;
    m_dout = 8'h00;
  endtask

  task automatic model_lookup(input logic [7:0] a, input bit wr, output int lat);
    int idx;
    int tg;
    idx = (int'(a) / W) % LINES;
    tg  = int'(a) / (W * LINES);
    if (cvalid[idx] && ctag[idx] == tg) begin
      lat = 2;
      if (m_hits < 65535) m_hits++;
    end else begin
      lat = (cvalid[idx] && cdirty[idx]) ? 3 + 2 * WL : 3 + WL;
      if (m_misses < 65535) m_misses++;
      cvalid[idx] = 1'b1;
      cdirty[idx] = 1'b0;
      ctag[idx]   = tg;
    end
    if (wr) cdirty[idx] = 1'b1;
  endtask

  task automatic model_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                           input bit ind, output int lat);
    int l1;
    int l2;
    int nd;
    logic [7:0] ea;
    lat = 0;
    case (op)
      2'b01: begin
        if (ind) begin
          model_lookup(a, 1'b0, l1);
          ea = mem[a];
          model_lookup(ea, 1'b0, l2);
          lat = l1 + l2 - 1;
          m_dout = mem[ea];
        end else begin
          model_lookup(a, 1'b0, lat);
          m_dout = mem[a];
        end
      end
      2'b10: begin
        model_lookup(a, 1'b1, lat);
        mem[a] = d;
      end
      2'b11: begin
        nd = 0;
        for (int i = 0; i < LINES; i++) begin
          if (cvalid[i] && cdirty[i]) begin
            nd++;
            cdirty[i] = 1'b0;
          end
        end
        lat = LINES + 1 + nd * WL;
      end
      default: lat = 0;
    endcase
  endtask

  // Issues one request and checks outputs on every cycle until two cycles past completion.
  task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input bit ind, input bit hold, input int lit_lat, input int lit_data);
    int lat;
    int seen;
    logic [7:0] old_dout;
    old_dout = m_dout;
    model_txn(op, a, d, ind, lat);
    seen = -1;
    @(negedge clk);
    req = 1'b1; cntrl = op; addr = a; dataIn = d; isIndirect = ind;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      if (!hold || c >= lat) req = 1'b0;
      if (!hold) cntrl = 2'($urandom);
      addr = 8'($urandom);
      dataIn = 8'($urandom);
      isIndirect = 1'($urandom);
      chk("busy", busy, (c <= lat) ? 1 : 0);
      chk("dataReady", dataReady, (c == lat) ? 1 : 0);
      chk("dataOut", dataOut, (c >= lat) ? m_dout : old_dout);
      if (dataReady === 1'b1 && seen < 0) seen = c;
    end
    chk("hitCount", hitCount, m_hits);
    chk("missCount", missCount, m_misses);
    if (lit_lat >= 0) chk("latency_literal", seen, lit_lat);
    if (lit_data >= 0) chk("dataOut_literal", dataOut, lit_data);
    $display("txn op=%0d addr=%02h din=%02h ind=%0d hold=%0d lat=%0d seen=%0d dout=%02h hits=%0d misses=%0d",
             op, a, d, ind, hold, lat, seen, dataOut, hitCount, missCount);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 1'b0;
    clrN = 1'b0;
    #1;
    chk("rst_dataOut", dataOut, 0);
    chk("rst_dataReady", dataReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_missCount", missCount, 0);
    model_reset();
    @(negedge clk);
    clrN = 1'b1;
  endtask

  initial begin
    int h0;
    int r;
    logic [7:0] ra;
    logic [1:0] rop;
    bit rind;

    model_reset();
    do_reset();

    // Cold read miss then hit.
    run_txn(2'b01, 8'h11, 8'h00, 1'b0, 1'b0, 7, 8'h00);
    chk("missCount_literal", missCount, 1);
    run_txn(2'b01, 8'h11, 8'h00, 1'b0, 1'b0, 2, 8'h00);
    chk("hitCount_literal", hitCount, 1);

    // Write-allocate, dirty eviction, read back through a second dirty eviction.
    run_txn(2'b10, 8'h04, 8'h5A, 1'b0, 1'b0, 7, -1);
    run_txn(2'b10, 8'h24, 8'h77, 1'b0, 1'b0, 11, -1);
    run_txn(2'b01, 8'h04, 8'h00, 1'b0, 1'b0, 11, 8'h5A);

    // Indirect read where pointer and target share a line index.
    run_txn(2'b10, 8'h08, 8'h30, 1'b0, 1'b0, 7, -1);
    run_txn(2'b10, 8'h30, 8'hAB, 1'b0, 1'b0, 11, -1);
    run_txn(2'b01, 8'h08, 8'h00, 1'b1, 1'b0, 17, 8'hAB);

    // Indirect read with both stages cached.
    run_txn(2'b10, 8'h0A, 8'h30, 1'b0, 1'b0, 7, -1);
    h0 = m_hits;
    run_txn(2'b01, 8'h0A, 8'h00, 1'b1, 1'b0, 3, 8'hAB);
    chk("indirect_hits_plus2", hitCount, h0 + 2);

    // Flush with all four lines dirty.
    do_reset();
    run_txn(2'b10, 8'h00, 8'h11, 1'b0, 1'b0, 7, -1);
    run_txn(2'b10, 8'h02, 8'h22, 1'b0, 1'b0, 7, -1);
    run_txn(2'b10, 8'h04, 8'h33, 1'b0, 1'b0, 7, -1);
    run_txn(2'b10, 8'h06, 8'h44, 1'b0, 1'b0, 7, -1);
    run_txn(2'b11, 8'h00, 8'h00, 1'b0, 1'b0, 21, -1);
    run_txn(2'b01, 8'h40, 8'h00, 1'b0, 1'b0, 7, 8'h00);
    run_txn(2'b01, 8'h00, 8'h00, 1'b0, 1'b0, 7, 8'h11);

    // req held high with changing inputs through a miss.
    run_txn(2'b10, 8'h0C, 8'h99, 1'b0, 1'b1, 7, -1);
    run_txn(2'b01, 8'h0C, 8'h00, 1'b0, 1'b0, 2, 8'h99);

    // req with cntrl=00 is not a request.
    run_txn(2'b00, 8'h0C, 8'h00, 1'b0, 1'b0, -1, -1);

    // Random traffic, biased toward a small address window for hits and conflicts.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      rind = 1'b0;
      if (r <= 3) rop = 2'b01;
      else if (r == 4) begin rop = 2'b01; rind = 1'b1; end
      else if (r <= 7) rop = 2'b10;
      else if (r == 8) rop = 2'b11;
      else rop = 2'b00;
      run_txn(rop, ra, 8'($urandom), rind, ($urandom_range(0, 7) == 0), -1, -1);
    end

    // Asynchronous reset in the middle of an eviction.
    do_reset();
    run_txn(2'b10, 8'h04, 8'h5A, 1'b0, 1'b0, 7, -1);
    run_txn(2'b01, 8'h04, 8'h00, 1'b0, 1'b0, 2, 8'h5A);
    @(negedge clk);
    req = 1'b1; cntrl = 2'b10; addr = 8'h24; dataIn = 8'h77; isIndirect = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("busy_in_evict", busy, 1);
    @(negedge clk);
    #1;
    clrN = 1'b0;
    #1;
    chk("midrst_dataOut", dataOut, 0);
    chk("midrst_dataReady", dataReady, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hitCount", hitCount, 0);
    chk("midrst_missCount", missCount, 0);
    model_reset();
    @(negedge clk);
    clrN = 1'b1;
    run_txn(2'b01, 8'h04, 8'h00, 1'b0, 1'b0, 7, 8'h00);
    chk("missCount_after_reset", missCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
